// File: rtl/nes_pkg.sv
// rtl/nes_pkg.sv - shared state type and constants for the NES pad reader
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    DONE
  } nes_state_t;

  localparam int NES_BITS    = 8;
  localparam int NES_IDX_W   = 3;
  localparam int LATCH_TICKS = 2;

  // Bit positions of the buttons in buttons_p1/p2 (serial order of the pad)
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_shift_rx.sv
// rtl/nes_shift_rx.sv - per-pad serial receiver: 2-flop synchronizer, inverter, indexed capture register
module nes_shift_rx
  import nes_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 nes_data,
  input  logic                 sample_en,
  input  logic [NES_IDX_W-1:0] bit_idx,
  output logic [NES_BITS-1:0]  bits_next
);

  logic [1:0]          sync_q;
  logic [NES_BITS-1:0] bits_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], nes_data};
    end
  end

  // Exposed as next-state so the top can publish the final bit in the same edge it is sampled
  always_comb begin
    bits_next = bits_q;
    if (sample_en) begin
      bits_next[bit_idx] = ~sync_q[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bits_q <= '0;
    end else begin
      bits_q <= bits_next;
    end
  end

endmodule

// File: rtl/nes_pad_reader.sv
// rtl/nes_pad_reader.sv - two-pad NES controller poller with periodic and on-demand reads
// Optional NES_EDGE_OUT_EN adds pressed_p1/p2 newly-pressed strobes in the DONE cycle.
module nes_pad_reader
  import nes_pkg::*;
#(
  parameter int TICK_CYCLES = 150,
  parameter int POLL_CYCLES = 416667
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       poll_now,
  input  logic       nes_data_p1,
  input  logic       nes_data_p2,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons_p1,
  output logic [7:0] buttons_p2,
  output logic       valid,
  output logic       busy
`ifdef NES_EDGE_OUT_EN
  ,
  output logic [7:0] pressed_p1,
  output logic [7:0] pressed_p2
`endif
);

  localparam int TKW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int PW  = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

  nes_state_t           state;
  logic [TKW-1:0]       tick;
  logic [PW-1:0]        poll_timer;
  logic [1:0]           latch_cnt;
  logic [NES_IDX_W-1:0] bit_idx;
  logic                 tick_last;
  logic                 poll_expired;
  logic                 trigger;
  logic                 sample_en;
  logic                 capture_done;
  logic [NES_BITS-1:0]  rx_next_p1;
  logic [NES_BITS-1:0]  rx_next_p2;

  assign tick_last    = (tick == TKW'(TICK_CYCLES - 1));
  assign poll_expired = (poll_timer == PW'(POLL_CYCLES - 1));
  assign trigger      = (state == IDLE) && (poll_expired || poll_now);
  assign sample_en    = (state == LOW) && tick_last;
  assign capture_done = sample_en && (bit_idx == NES_IDX_W'(NES_BITS - 1));

  // Free-running; restarted by any accepted trigger so polls stay a full period apart
  always_ff @(posedge clk) begin
    if (!reset_n || trigger || poll_expired) begin
      poll_timer <= '0;
    end else begin
      poll_timer <= poll_timer + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      tick       <= '0;
      latch_cnt  <= '0;
      bit_idx    <= '0;
      nes_latch  <= 1'b0;
      nes_clk    <= 1'b0;
      buttons_p1 <= '0;
      buttons_p2 <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= 1'b0;
      tick  <= tick_last ? '0 : tick + TKW'(1);
      case (state)
        IDLE: begin
          if (trigger) begin
            state     <= LATCH;
            tick      <= '0;
            latch_cnt <= '0;
            nes_latch <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LATCH: begin
          if (tick_last) begin
            if (latch_cnt == 2'(LATCH_TICKS - 1)) begin
              state     <= LOW;
              nes_latch <= 1'b0;
              bit_idx   <= '0;
            end else begin
              latch_cnt <= latch_cnt + 2'd1;
            end
          end
        end
        LOW: begin
          if (capture_done) begin
            state      <= DONE;
            buttons_p1 <= rx_next_p1;
            buttons_p2 <= rx_next_p2;
            valid      <= 1'b1;
          end else if (tick_last) begin
            state   <= HIGH;
            nes_clk <= 1'b1;
          end
        end
        HIGH: begin
          if (tick_last) begin
            state   <= LOW;
            nes_clk <= 1'b0;
            bit_idx <= bit_idx + NES_IDX_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          tick  <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          nes_latch <= 1'b0;
          nes_clk   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  nes_shift_rx u_rx_p1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .nes_data  (nes_data_p1),
    .sample_en (sample_en),
    .bit_idx   (bit_idx),
    .bits_next (rx_next_p1)
  );

  nes_shift_rx u_rx_p2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .nes_data  (nes_data_p2),
    .sample_en (sample_en),
    .bit_idx   (bit_idx),
    .bits_next (rx_next_p2)
  );

`ifdef NES_EDGE_OUT_EN
  // Compared against the buttons still held from the previous poll
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pressed_p1 <= '0;
      pressed_p2 <= '0;
    end else if (capture_done) begin
      pressed_p1 <= rx_next_p1 & ~buttons_p1;
      pressed_p2 <= rx_next_p2 & ~buttons_p2;
    end else begin
      pressed_p1 <= '0;
      pressed_p2 <= '0;
    end
  end
`endif

endmodule

// File: doc/nes_pad_reader.md
Name: nes_pad_reader

Overview:
Console-side reader for two NES controllers. It drives the shared NES latch and clock lines and shifts in 8 serial button bits from each pad. It polls automatically at a fixed frame rate, or on request. It delivers registered, active-high button vectors to the Pong game logic, with a one-cycle valid strobe.

Parameters:
TICK_CYCLES, 150, clk cycles per protocol tick T (6 us at 25 MHz); legal range ≥4
POLL_CYCLES, 416667, clk cycles between automatic polls (60 Hz at 25 MHz); must exceed 17*TICK_CYCLES+2

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
poll_now  in  1  request an immediate poll; honoured only in IDLE
nes_data_p1  in  1  serial data from pad 1; active-low (0 = pressed)
nes_data_p2  in  1  serial data from pad 2; active-low
nes_latch  out  1  latch strobe to both pads
nes_clk  out  1  shift clock to both pads; idles low
buttons_p1  out  8  pad 1 buttons, active-high: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
buttons_p2  out  8  pad 2 buttons, same bit order
valid  out  1  one-cycle pulse when buttons_p1/p2 update
busy  out  1  high from LATCH entry through DONE

Behaviour:
- Reset values: nes_latch=0, nes_clk=0, buttons_p1/p2=0, valid=0, busy=0. State=IDLE, poll timer=0, bit index=0, synchronizers=1.
- Reset taken mid-transaction: return to IDLE on the next edge. No valid pulse; outputs are cleared as above.
- nes_data_p1/p2 each pass through a 2-flop synchronizer before sampling.
- Poll timer:
  - Free-runs 0..POLL_CYCLES-1 and wraps.
  - Its terminal count is a trigger only in IDLE.
  - Any accepted trigger (timer or poll_now) resets the timer to 0.
  - Timer expiry and poll_now in the same cycle start a single transaction.
  - poll_now is ignored while busy=1 and is not queued.
- Tick counter: counts 0..TICK_CYCLES-1 within each phase and clears on every state change.
- FSM. Trigger seen in IDLE at cycle 0:
  - IDLE: nes_latch=0, nes_clk=0. On trigger, go to LATCH.
  - LATCH: nes_latch=1 for exactly 2T cycles (cycles 1..2T), then go to LOW with bit index i=0.
  - LOW: nes_clk=0 for T cycles. On the last cycle of the phase, shift the inverted synchronized data of each pad into bit i. Then go to HIGH if i<7, or DONE if i==7.
  - HIGH: nes_clk=1 for T cycles, then i=i+1 and go to LOW.
  - DONE: lasts one cycle (cycle 17T+1). buttons_p1/p2 load from the shift registers, valid=1, then go to IDLE.
- Transaction shape: 2T latch + 8T low + 7T high. Exactly 7 nes_clk rising edges per transaction.
- buttons_p1/p2 hold their value between DONE cycles and never change mid-transaction.
- Minimum spacing between transactions: 17T+2 cycles.

Optional Feature:
NES_EDGE_OUT_EN
- When defined, adds outputs pressed_p1[7:0] and pressed_p2[7:0].
  - In the DONE cycle they equal new_buttons & ~old_buttons; they are 0 in all other cycles.
  - Reset value is 0, and old_buttons is treated as 0 after reset.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package nes_pkg: state enum (IDLE, LATCH, LOW, HIGH, DONE); NES_BITS=8; LATCH_TICKS=2; button index constants BTN_A..BTN_RIGHT.
- Sub-module nes_shift_rx, instantiated once per pad: 2-flop synchronizer, inverter, 8-bit shift/capture register with sample-enable and bit-index inputs.
- The FSM, timers and the optional edge logic stay in the top module.

Test Plan (TICK_CYCLES=4, POLL_CYCLES=200):
1. Release reset, no poll_now -> all outputs 0 until the poll timer expires. nes_latch is then high for exactly 8 consecutive cycles, and busy is high through DONE.
2. Pad models: p1 drives low on bits 0 and 7, p2 all high -> valid pulses once at trigger+69 cycles with buttons_p1=8'h81, buttons_p2=8'h00.
3. Monitor nes_clk during one transaction -> exactly 7 rising edges, each high phase 4 cycles, low before each sample. nes_clk is never high while nes_latch is high.
4. Check poll_now in three cases:
   - Asserted during busy -> no extra transaction.
   - Asserted in IDLE -> nes_latch rises the next cycle.
   - Asserted on the same cycle as timer expiry -> exactly one transaction.
5. Drop reset_n for 1 cycle during the bit-3 HIGH phase -> next cycle nes_latch=0, nes_clk=0, buttons=0, no valid. The next latch occurs 200 cycles later.
6. NES_EDGE_OUT_EN defined; p1 holds Start across two polls -> pressed_p1=8'h08 on the first valid only, 8'h00 on the second.
